// File: rtl/neuron_nin_trace.sv
// N-channel event neuron: per-channel linearly decaying traces, a sequential MAC
// over a trace snapshot on each new event, threshold compare and refractory gating.
module neuron_nin_trace #(
   parameter int P_CH     = 25,
   parameter int p_width  = 8,
   parameter int p_shift  = 8,
   parameter int P_DECAY  = 1,
   parameter int P_REFRAC = 4,
   parameter int P_SUMW   = p_width + p_shift + $clog2(P_CH)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [P_CH-1:0]           i_event,
   input  logic                      i_tick,
   input  logic [P_SUMW-1:0]         i_threshold,
   input  logic [P_CH*p_width-1:0]   i_weight,
   output logic [P_CH-1:0]           o_sync,
   output logic [P_SUMW-1:0]         o_s,
   output logic                      o_valid,
   output logic                      o_spike,
   output logic [P_SUMW-1:0]         o_neuronout,
   output logic                      o_busy
);

   localparam int IDXW  = $clog2(P_CH);
   localparam int PRODW = p_width + p_shift;
   localparam int REFW  = (P_REFRAC < 1) ? 1 : $clog2(P_REFRAC + 1);
   localparam logic [p_shift-1:0] DECAY = p_shift'(P_DECAY);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_CMP} state_t;

   logic [p_shift-1:0] trace   [P_CH];
   logic [p_shift-1:0] shadow_q[P_CH];

   state_t              state_q;
   logic [IDXW-1:0]     idx_q;
   logic [P_SUMW-1:0]   acc_q;
   logic                pending_q;
   logic [REFW-1:0]     refrac_q;
   logic [P_CH-1:0]     sync_q;
   logic [P_SUMW-1:0]   s_q;
   logic [P_SUMW-1:0]   nout_q;
   logic                valid_q;
   logic                spike_q;
   logic [p_width-1:0]  w_sel;
   logic [PRODW-1:0]    prod;

   // Per-channel trace: an event reloads TMAX and beats a simultaneous tick.
   genvar gi;
   generate
      for (gi = 0; gi < P_CH; gi++) begin : g_ch
         logic [p_shift-1:0] t_q;
         logic [p_shift-1:0] t_d;

         always_comb begin
            t_d = t_q;
            if (i_event[gi]) begin
               t_d = '1;
            end else if (i_tick) begin
               t_d = (int'(t_q) > P_DECAY) ? (t_q - DECAY) : '0;
            end
         end

         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               t_q <= '0;
            end else begin
               t_q <= t_d;
            end
         end

         assign trace[gi] = t_q;
      end
   endgenerate

   always_comb begin
      w_sel = i_weight[idx_q*p_width +: p_width];
      prod  = PRODW'(shadow_q[idx_q]) * PRODW'(w_sel);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         pending_q <= 1'b0;
         refrac_q  <= '0;
         sync_q    <= '0;
         s_q       <= '0;
         nout_q    <= '0;
         valid_q   <= 1'b0;
         spike_q   <= 1'b0;
         for (int c = 0; c < P_CH; c++) begin
            shadow_q[c] <= '0;
         end
      end else begin
         sync_q  <= i_event;
         valid_q <= 1'b0;
         spike_q <= 1'b0;
         if (|i_event) begin
            pending_q <= 1'b1;
         end
         if (i_tick && (refrac_q != '0)) begin
            refrac_q <= refrac_q - REFW'(1);
         end

         case (state_q)
            S_IDLE: begin
               if (pending_q) begin
                  shadow_q <= trace;
                  acc_q    <= '0;
                  idx_q    <= '0;
                  if (!(|i_event)) begin
                     pending_q <= 1'b0;
                  end
                  state_q <= S_ACC;
               end
            end
            S_ACC: begin
               acc_q <= acc_q + P_SUMW'(prod);
               idx_q <= idx_q + IDXW'(1);
               if (idx_q == IDXW'(P_CH - 1)) begin
                  state_q <= S_CMP;
               end
            end
            S_CMP: begin
               s_q     <= acc_q;
               valid_q <= 1'b1;
               state_q <= S_IDLE;
               // A refractory reload here takes precedence over the tick decrement above.
               if ((acc_q > i_threshold) && (refrac_q == '0)) begin
                  spike_q  <= 1'b1;
                  nout_q   <= acc_q;
                  refrac_q <= REFW'(P_REFRAC);
               end else begin
                  nout_q <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_sync      = sync_q;
   assign o_s         = s_q;
   assign o_valid     = valid_q;
   assign o_spike     = spike_q;
   assign o_neuronout = nout_q;
   assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_nin_trace.sv
// Directed bench for neuron_nin_trace with the default 25-channel configuration.
module tb_neuron_nin_trace;
   localparam int CH = 25;
   localparam int W  = 8;
   localparam int SW = 21;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            tick = 1'b0;
   logic [CH-1:0]   ev = '0;
   logic [SW-1:0]   thr = '0;
   logic [CH*W-1:0] wt = '0;
   logic [CH-1:0]   o_sync;
   logic [SW-1:0]   o_s;
   logic            o_valid;
   logic            o_spike;
   logic [SW-1:0]   o_neuronout;
   logic            o_busy;

   int tests = 0;
   int fails = 0;

   neuron_nin_trace dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_event(ev), .i_tick(tick),
      .i_threshold(thr), .i_weight(wt), .o_sync(o_sync), .o_s(o_s),
      .o_valid(o_valid), .o_spike(o_spike), .o_neuronout(o_neuronout), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0; ev = '0; tick = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic fire(input int ch);
      ev[ch] = 1'b1;
      @(posedge clk); #1;
      ev = '0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         @(posedge clk); #1;
         tick = 1'b0;
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (o_valid) begin
            lat = i;
            break;
         end
      end
      $display("[TB] eval done lat=%0d s=%0d spike=%0d nout=%0d", lat, o_s, o_spike, o_neuronout);
   endtask

   task automatic test_reset();
      int nv;
      rst_n = 1'b0;
      repeat (2) begin
         ev = CH'($urandom); tick = 1'($urandom); thr = SW'($urandom);
         for (int c = 0; c < CH; c++) wt[c*W +: W] = W'($urandom);
         @(posedge clk); #1;
      end
      tests++; if (o_sync !== '0) begin fails++; $display("FAIL rst_sync got %0h exp 0", o_sync); end
      tests++; if (o_s !== '0) begin fails++; $display("FAIL rst_s got %0d exp 0", o_s); end
      tests++; if ({o_valid, o_spike, o_busy} !== 3'b000) begin fails++; $display("FAIL rst_flags got %b exp 000", {o_valid, o_spike, o_busy}); end
      tests++; if (o_neuronout !== '0) begin fails++; $display("FAIL rst_nout got %0d exp 0", o_neuronout); end
      ev = '0; tick = 1'b0; thr = '0; wt = '0;
      rst_n = 1'b1;
      nv = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (o_valid) nv++;
      end
      tests++; if (nv !== 0) begin fails++; $display("FAIL rst_quiet got %0d valids exp 0", nv); end
      $display("[TB] reset done, %0d valids after release", nv);
   endtask

   task automatic test_spike();
      int lat;
      do_reset();
      wt = '0; wt[0 +: W] = 8'd10; thr = 21'd2000;
      fire(0);
      tests++; if (o_sync !== 25'd1) begin fails++; $display("FAIL sync got %0h exp 1", o_sync); end
      @(posedge clk); #1;
      tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL busy_k1 got %b exp 1", o_busy); end
      wait_valid(lat);
      tests++; if (lat + 1 !== 27) begin fails++; $display("FAIL latency got %0d exp 27", lat + 1); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL busy_end got %b exp 0", o_busy); end
      tests++; if (o_spike !== 1'b1) begin fails++; $display("FAIL spike got %b exp 1", o_spike); end
      tests++; if (o_s !== 21'd2550) begin fails++; $display("FAIL sum got %0d exp 2550", o_s); end
      tests++; if (o_neuronout !== 21'd2550) begin fails++; $display("FAIL nout got %0d exp 2550", o_neuronout); end
      @(posedge clk); #1;
      tests++; if ({o_valid, o_spike} !== 2'b00) begin fails++; $display("FAIL pulse_width got %b exp 00", {o_valid, o_spike}); end
      tests++; if (o_s !== 21'd2550 || o_neuronout !== 21'd2550) begin fails++; $display("FAIL hold got %0d/%0d exp 2550/2550", o_s, o_neuronout); end

      do_reset();
      thr = 21'd2550;
      fire(0);
      wait_valid(lat);
      tests++; if (lat !== 27) begin fails++; $display("FAIL latency_eq got %0d exp 27", lat); end
      tests++; if (o_s !== 21'd2550) begin fails++; $display("FAIL sum_eq got %0d exp 2550", o_s); end
      tests++; if (o_spike !== 1'b0 || o_neuronout !== '0) begin fails++; $display("FAIL nospike got %b/%0d exp 0/0", o_spike, o_neuronout); end
   endtask

   task automatic test_decay();
      int lat;
      do_reset();
      wt = '0; wt[3*W +: W] = 8'd4; thr = '1;
      fire(3); wait_valid(lat);
      tests++; if (o_s !== 21'd1020) begin fails++; $display("FAIL decay_first got %0d exp 1020", o_s); end
      ticks(5);
      fire(4); wait_valid(lat);
      tests++; if (o_s !== 21'd1000) begin fails++; $display("FAIL decay_5 got %0d exp 1000", o_s); end
      ticks(300);
      fire(4); wait_valid(lat);
      tests++; if (lat !== 27 || o_s !== '0) begin fails++; $display("FAIL decay_sat got lat %0d s %0d exp 27/0", lat, o_s); end
   endtask

   task automatic test_collision();
      int lat;
      do_reset();
      wt = '0; wt[0 +: W] = 8'd1; thr = '1;
      ev[0] = 1'b1; tick = 1'b1;
      @(posedge clk); #1;
      ev = '0; tick = 1'b0;
      wait_valid(lat);
      tests++; if (o_s !== 21'd255) begin fails++; $display("FAIL collision got %0d exp 255", o_s); end
   endtask

   task automatic test_refractory();
      int lat;
      do_reset();
      wt = '0; wt[0 +: W] = 8'd1; thr = '0;
      fire(0); wait_valid(lat);
      tests++; if (o_spike !== 1'b1) begin fails++; $display("FAIL refr_first got %b exp 1", o_spike); end
      ticks(3);
      fire(0); wait_valid(lat);
      tests++; if ({o_valid, o_spike} !== 2'b10 || o_neuronout !== '0) begin fails++; $display("FAIL refr_block got v%b s%b n%0d exp v1 s0 n0", o_valid, o_spike, o_neuronout); end
      ticks(1);
      fire(0); wait_valid(lat);
      tests++; if (o_spike !== 1'b1 || o_neuronout !== 21'd255) begin fails++; $display("FAIL refr_release got s%b n%0d exp s1 n255", o_spike, o_neuronout); end
   endtask

   task automatic test_back_to_back();
      int n, e1, e2;
      logic [SW-1:0] s1, s2;
      do_reset();
      wt = '0; wt[1*W +: W] = 8'd2; wt[2*W +: W] = 8'd3; thr = '1;
      n = 0; e1 = -1; e2 = -1; s1 = '0; s2 = '0;
      fire(1);
      for (int e = 1; e <= 60; e++) begin
         if (e == 5) ev[2] = 1'b1;
         @(posedge clk); #1;
         ev = '0;
         if (o_valid) begin
            n++;
            if (n == 1) begin e1 = e; s1 = o_s; end
            if (n == 2) begin e2 = e; s2 = o_s; end
         end
      end
      $display("[TB] back_to_back valids=%0d at %0d,%0d sums %0d,%0d", n, e1, e2, s1, s2);
      tests++; if (n !== 2) begin fails++; $display("FAIL b2b_count got %0d exp 2", n); end
      tests++; if (e1 !== 27 || e2 !== 54) begin fails++; $display("FAIL b2b_timing got %0d,%0d exp 27,54", e1, e2); end
      tests++; if (s1 !== 21'd510) begin fails++; $display("FAIL b2b_sum1 got %0d exp 510", s1); end
      tests++; if (s2 !== 21'd1275) begin fails++; $display("FAIL b2b_sum2 got %0d exp 1275", s2); end
   endtask

   task automatic test_abort();
      int n;
      n = 0;
      fire(1);
      for (int e = 1; e <= 50; e++) begin
         rst_n = (e != 10);
         @(posedge clk); #1;
         if (o_valid) n++;
      end
      rst_n = 1'b1;
      $display("[TB] abort valids=%0d s=%0d nout=%0d busy=%b", n, o_s, o_neuronout, o_busy);
      tests++; if (n !== 0) begin fails++; $display("FAIL abort_valid got %0d exp 0", n); end
      tests++; if (o_s !== '0 || o_neuronout !== '0) begin fails++; $display("FAIL abort_outs got %0d/%0d exp 0/0", o_s, o_neuronout); end
      tests++; if (o_busy !== 1'b0 || o_sync !== '0) begin fails++; $display("FAIL abort_busy got %b/%0h exp 0/0", o_busy, o_sync); end
   endtask

   initial begin
      test_reset();
      test_spike();
      test_decay();
      test_collision();
      test_refractory();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/neuron_nin_trace.md
# neuron_nin_trace

Parametrised successor of the fixed 25-input neuron. It takes N event channels and keeps a per-channel, linearly decaying time trace. On every new event it evaluates the weighted trace sum with a sequential MAC, then compares the sum against the threshold, with a refractory period after each spike. It sits in the same place in the ODESA digit-recognition layers as the earlier neuron.

## Interface
Parameters:
- P_CH, 25, number of input channels (≥2)
- p_width, 8, unsigned weight width
- p_shift, 8, trace width; trace maximum TMAX = 2^p_shift−1
- P_DECAY, 1, trace decrement per i_tick
- P_REFRAC, 4, refractory length in i_tick strobes
- P_SUMW, p_width+p_shift+$clog2(P_CH), derived sum width (cannot overflow)

Ports:
- i_clk  in  1  clock; all logic is on its rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_event  in  P_CH  per-channel event pulses, bit c = channel c
- i_tick  in  1  decay strobe, one cycle wide
- i_threshold  in  P_SUMW  unsigned firing threshold
- i_weight  in  P_CH*p_width  weight c at bits [c*p_width +: p_width], unsigned
- o_sync  out  P_CH  registered copy of i_event
- o_s  out  P_SUMW  last completed weighted sum
- o_valid  out  1  one-cycle pulse when o_s updates
- o_spike  out  1  one-cycle pulse, registered together with o_valid
- o_neuronout  out  P_SUMW  sum if spiked, else 0; held until the next evaluation
- o_busy  out  1  high while the FSM is not IDLE

## Operation
- **Reset:**
  - All traces are 0; the pending flag is 0; the refractory counter is 0; the FSM is IDLE.
  - Every output is 0.
- **Trace update (every cycle, per channel c):**
  - If i_event[c] is high, t[c] becomes TMAX.
  - Else if i_tick is high, t[c] becomes max(t[c]−P_DECAY, 0), saturating at 0.
  - Event and tick in the same cycle on the same channel: the event wins.
- **Pending flag:**
  - Set if any i_event bit is high.
  - Cleared when IDLE starts an evaluation.
  - A set request wins over a clear in the same cycle.
- **FSM:**
  - IDLE: if pending is set, snapshot all t[c] into a shadow register, set acc=0 and idx=0, clear pending, and go to ACC.
  - ACC: acc += shadow[idx]*w[idx] and idx++. After the accumulate with idx=P_CH−1, go to CMP. This takes exactly P_CH cycles.
  - CMP: register o_s=acc, pulse o_valid, and go to IDLE.
    - If acc > i_threshold (strictly, unsigned) and the refractory counter is 0: pulse o_spike, set o_neuronout=acc, and load the refractory counter with P_REFRAC.
    - Otherwise: set o_neuronout=0, with no spike.
- **During an evaluation:**
  - Events during ACC/CMP update the live traces and set pending, which triggers exactly one follow-up evaluation.
  - The evaluation in progress uses only its snapshot.
- **Refractory counter:**
  - Decrements on each i_tick while it is nonzero.
  - A load in CMP overrides a decrement in the same cycle.
- **Arithmetic:** all arithmetic is unsigned. The products are p_width+p_shift bits and the accumulator is P_SUMW bits.
- **Weights and threshold:** i_weight and i_threshold are sampled live. They must be held stable while o_busy is high.

## Timing
- o_sync[c] is high in the cycle after i_event[c] is sampled.
- Event sampled at edge k:
  - Pending is set at edge k.
  - ACC is entered at edge k+1.
  - CMP is entered at edge k+P_CH+1.
  - o_valid/o_spike/o_s/o_neuronout update at edge k+P_CH+2.
  - Latency is therefore P_CH+2 cycles; for P_CH=25 it is 27 cycles.
- o_busy is high from edge k+1 through edge k+P_CH+2 (exclusive), i.e. P_CH+1 cycles.
- Back-to-back evaluations: a new evaluation can start at the first IDLE cycle after CMP. The minimum spacing between o_valid pulses is P_CH+2 cycles.
- o_s and o_neuronout hold between o_valid pulses.
- Reset mid-evaluation: asserting i_rst_n=0 at any edge returns to IDLE with all state cleared. No o_valid is produced for the aborted evaluation.

## Test plan
- **Reset:** drive i_rst_n=0 for 2 cycles with random inputs -> all outputs 0, o_busy=0; no o_valid in the 30 cycles after release with no events.
- **Single event, spike/no-spike:** w0=10, others 0; event ch0 at edge k.
  - i_threshold=2000 -> o_valid, o_spike, o_s=2550 and o_neuronout=2550 at edge k+27.
  - Repeat from reset with i_threshold=2550 -> o_s=2550, o_spike=0, o_neuronout=0.
- **Decay:** w3=4, w4=0; event ch3, wait out its evaluation, apply 5 i_tick, then event ch4 -> second o_s=1000 (trace 250). Then apply 300 ticks and event ch4 -> o_s=0 (saturated, no wrap).
- **Tick/event collision:** event ch0 and i_tick in the same cycle, w0=1 -> o_s=255.
- **Refractory:** threshold 0, w0=1.
  - Spike, then event ch0 again with fewer than 4 ticks applied -> o_valid=1, o_spike=0, o_neuronout=0.
  - After 4 ticks, event ch0 -> o_spike=1.
- **Event during busy and reset abort:**
  - Event ch1 at k, event ch2 at k+5 -> exactly two o_valid pulses, at k+27 and k+54. The first sum excludes ch2.
  - Reset at k+10 -> no o_valid, and all outputs are 0.
